flash_data_master: RTL and testbench

//  Parametrised Avalon-MM master for the on-chip flash data port; successor to the fixed 17-bit/4-bit-burst data engine.

---
 rtl/flash_data_master_pkg.sv | 34 +++
 rtl/flash_data_master_if.sv | 47 ++++
 rtl/flash_data_master_timeout.sv | 29 ++
 rtl/flash_data_master.sv | 193 +++++++++++++++++++
 tb/tb_flash_data_master.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_data_master_pkg.sv
// Shared types and constants for the flash data-port master.
// Command opcodes, error codes and FSM states live here so the top and bench agree.
package flash_data_master_pkg;

    localparam int unsigned FLASH_BYTE_ADDR_W = 24;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_BRD = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        E_OK      = 2'b00,
        E_RANGE   = 2'b01,
        E_LEN     = 2'b10,
        E_TIMEOUT = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdData,
        StWrReq,
        StDone
    } state_t;

    // States in which a bus transfer is outstanding and the timeout runs.
    function automatic logic is_busy(state_t s);
        return (s == StRdReq) || (s == StRdData) || (s == StWrReq);
    endfunction

endpackage

// File: rtl/flash_data_master_if.sv
// Sequencer command port plus Avalon-MM data-port signals of flash_data_master.
// master: the flash_data_master side; slave: the sequencer/flash side.
interface flash_data_master_if
    import flash_data_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BURST_W = 4
) ();

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_op;
    logic [FLASH_BYTE_ADDR_W-1:0] cmd_addr;
    logic [BURST_W-1:0]           cmd_len;
    logic [DATA_W-1:0]            cmd_wdata;

    logic                         rd_valid;
    logic [DATA_W-1:0]            rd_data;
    logic                         rd_last;
    logic                         done;
    logic [1:0]                   err;

    logic [ADDR_W-1:0]            av_address;
    logic                         av_read;
    logic                         av_write;
    logic [DATA_W-1:0]            av_writedata;
    logic [BURST_W-1:0]           av_burstcount;
    logic                         av_waitrequest;
    logic                         av_readdatavalid;
    logic [DATA_W-1:0]            av_readdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata,
        input  av_waitrequest, av_readdatavalid, av_readdata,
        output cmd_ready, rd_valid, rd_data, rd_last, done, err,
        output av_address, av_read, av_write, av_writedata, av_burstcount
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata,
        output av_waitrequest, av_readdatavalid, av_readdata,
        input  cmd_ready, rd_valid, rd_data, rd_last, done, err,
        input  av_address, av_read, av_write, av_writedata, av_burstcount
    );

endinterface

// File: rtl/flash_data_master_timeout.sv
// Saturating no-progress counter; expired once TIMEOUT_CYC enabled cycles pass without a clear.
module flash_data_master_timeout #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/flash_data_master.sv
// Avalon-MM master for the on-chip flash data port: one command at a time
// (single read, burst read, single write) with range/length checks and a stall timeout.
module flash_data_master
    import flash_data_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BURST_W     = 4,
    parameter int unsigned MAX_BURST   = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input logic                 clk,
    input logic                 reset,
    flash_data_master_if.master bus
);

    localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] ONE     = BURST_W'(1);

    state_t             r_state;
    logic               r_cmd_ready;
    logic [BURST_W-1:0] r_len;
    logic [BURST_W-1:0] r_beat;
    logic [BURST_W-1:0] r_av_burstcount;
    logic [ADDR_W-1:0]  r_av_address;
    logic [DATA_W-1:0]  r_av_writedata;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_av_read;
    logic               r_av_write;
    logic               r_rd_valid;
    logic               r_rd_last;
    logic               r_done;
    err_t               r_err;

    op_t                w_op;
    logic               w_accept;
    logic               w_range_bad;
    logic               w_len_bad;
    logic [BURST_W-1:0] w_len;
    logic               w_busy;
    logic               w_beat;
    logic [BURST_W-1:0] w_beat_next;
    logic               w_last;
    logic               w_req_ack;
    logic               w_progress;
    logic               w_expired;
    logic               w_abort;

    assign w_op        = op_t'(bus.cmd_op);
    assign w_accept    = bus.cmd_valid && r_cmd_ready;
    assign w_len_bad   = (w_op == OP_RSV) ||
                         ((w_op == OP_BRD) && ((bus.cmd_len == '0) || (bus.cmd_len > MAX_LEN)));
    assign w_len       = (w_op == OP_BRD) ? bus.cmd_len : ONE;
    assign w_busy      = is_busy(r_state);
    // Beats are taken in RD_REQ too, so a slave answering in the accept cycle is not lost.
    assign w_beat      = ((r_state == StRdReq) || (r_state == StRdData)) && bus.av_readdatavalid;
    assign w_beat_next = r_beat + ONE;
    assign w_last      = w_beat && (w_beat_next == r_len);
    assign w_req_ack   = ((r_state == StRdReq) || (r_state == StWrReq)) && !bus.av_waitrequest;
    assign w_progress  = w_accept || w_req_ack || w_beat;
    assign w_abort     = w_busy && w_expired && !w_progress;

    if (ADDR_W + 2 < FLASH_BYTE_ADDR_W) begin : g_range
        assign w_range_bad = |bus.cmd_addr[FLASH_BYTE_ADDR_W-1:ADDR_W+2];
    end else begin : g_no_range
        assign w_range_bad = 1'b0;
    end

    flash_data_master_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_progress),
        .i_en     (w_busy),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= StIdle;
            r_cmd_ready     <= 1'b1;
            r_len           <= '0;
            r_beat          <= '0;
            r_av_burstcount <= '0;
            r_av_address    <= '0;
            r_av_writedata  <= '0;
            r_rd_data       <= '0;
            r_av_read       <= 1'b0;
            r_av_write      <= 1'b0;
            r_rd_valid      <= 1'b0;
            r_rd_last       <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= E_OK;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
            if (w_beat) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= bus.av_readdata;
                r_rd_last  <= w_last;
                r_beat     <= w_beat_next;
            end
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cmd_ready     <= 1'b0;
                        r_err           <= E_OK;
                        r_av_address    <= bus.cmd_addr[ADDR_W+1:2];
                        r_av_writedata  <= bus.cmd_wdata;
                        r_len           <= w_len;
                        r_av_burstcount <= w_len;
                        r_beat          <= '0;
                        if (w_range_bad) begin
                            r_err   <= E_RANGE;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else if (w_len_bad) begin
                            r_err   <= E_LEN;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else if (w_op == OP_WR) begin
                            r_av_write <= 1'b1;
                            r_state    <= StWrReq;
                        end else begin
                            r_av_read <= 1'b1;
                            r_state   <= StRdReq;
                        end
                    end
                end
                StRdReq: begin
                    if (w_last) begin
                        r_av_read <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= StDone;
                    end else if (w_req_ack) begin
                        r_av_read <= 1'b0;
                        r_state   <= StRdData;
                    end else if (w_abort) begin
                        r_av_read <= 1'b0;
                        r_err     <= E_TIMEOUT;
                        r_done    <= 1'b1;
                        r_state   <= StDone;
                    end
                end
                StRdData: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else if (w_abort) begin
                        r_err   <= E_TIMEOUT;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StWrReq: begin
                    if (w_req_ack) begin
                        r_av_write <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= StDone;
                    end else if (w_abort) begin
                        r_av_write <= 1'b0;
                        r_err      <= E_TIMEOUT;
                        r_done     <= 1'b1;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_last       = r_rd_last;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.av_address    = r_av_address;
    assign bus.av_read       = r_av_read;
    assign bus.av_write      = r_av_write;
    assign bus.av_writedata  = r_av_writedata;
    assign bus.av_burstcount = r_av_burstcount;

endmodule

// File: tb/tb_flash_data_master.sv
// Bench for flash_data_master: command table with an in-line flash slave model,
// read beats checked through a scoreboard queue, plus reset, stray-beat and timeout sequences.
module tb_flash_data_master;
    import flash_data_master_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [3:0]  len;
        logic [31:0] wdata;
        int          wait_cyc;
        int          gap;
        logic [1:0]  exp_err;
        logic [16:0] exp_addr;
        logic [3:0]  exp_burst;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    flash_data_master_if if_a ();
    flash_data_master_if if_b ();

    flash_data_master u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (if_a)
    );

    flash_data_master #(
        .TIMEOUT_CYC(16)
    ) u_dut_to (
        .clk  (clk),
        .reset(reset),
        .bus  (if_b)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cycles = 0;
    logic [1:0]  last_err = 2'b00;
    logic        prev_done = 1'b0;
    beat_t       q[$];
    beat_t       m_e;
    int          b_rd = 0;
    int          b_last = 0;
    int          b_done = 0;
    logic [1:0]  b_err = 2'b00;
    logic [31:0] b_data = '0;
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] seed, input int i);
        return seed + (32'h0101_0101 * 32'(i));
    endfunction

    // Scoreboard side of DUT a
    always @(negedge clk) begin
        if (!reset) begin
            if (if_a.rd_valid) begin
                rd_cnt++;
                chk("beat_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    m_e = q.pop_front();
                    chk("rd_data", 64'(if_a.rd_data), 64'(m_e.data));
                    chk("rd_last", 64'(if_a.rd_last), 64'(m_e.last));
                end
            end
            if (if_a.done) begin
                done_cnt++;
                last_err = if_a.err;
                chk("done_one_cycle", 64'(prev_done), 64'd0);
                chk("ready_low_in_done", 64'(if_a.cmd_ready), 64'd0);
            end
            if (if_a.av_write) wr_cycles++;
            prev_done = if_a.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (if_b.rd_valid) begin
                b_rd++;
                b_data = if_b.rd_data;
            end
            if (if_b.rd_last) b_last++;
            if (if_b.done) begin
                b_done++;
                b_err = if_b.err;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   start_done;
        int   start_rd;
        int   start_wr;
        int   nbeats;
        int   cyc;
        logic seen;
        start_done = done_cnt;
        start_rd   = rd_cnt;
        start_wr   = wr_cycles;
        nbeats     = (v.exp_err != 2'b00 || v.op == OP_WR) ? 0 : ((v.op == OP_BRD) ? int'(v.len) : 1);
        @(negedge clk);
        if_a.cmd_valid = 1'b1;
        if_a.cmd_op    = v.op;
        if_a.cmd_addr  = v.addr;
        if_a.cmd_len   = v.len;
        if_a.cmd_wdata = v.wdata;
        @(negedge clk);
        if_a.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            if (if_a.av_read || if_a.av_write || if_a.done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("cmd_reaction", 64'(seen), 64'd1);
        if (v.exp_err != 2'b00) begin
            chk("no_bus_cycle", 64'({if_a.av_read, if_a.av_write}), 64'd0);
            chk("err_done_next", 64'(if_a.done), 64'd1);
        end else if (v.op == OP_WR) begin
            chk("wr_strobe", 64'(if_a.av_write), 64'd1);
            chk("wr_addr", 64'(if_a.av_address), 64'(v.exp_addr));
            chk("wr_burst", 64'(if_a.av_burstcount), 64'(v.exp_burst));
            chk("wr_data", 64'(if_a.av_writedata), 64'(v.wdata));
            repeat (v.wait_cyc) @(negedge clk);
            chk("wr_held", 64'(if_a.av_write), 64'd1);
            chk("wr_data_stable", 64'(if_a.av_writedata), 64'(v.wdata));
            if_a.av_waitrequest = 1'b0;
            @(negedge clk);
            if_a.av_waitrequest = 1'b1;
        end else begin
            chk("rd_strobe", 64'(if_a.av_read), 64'd1);
            chk("rd_addr", 64'(if_a.av_address), 64'(v.exp_addr));
            chk("rd_burst", 64'(if_a.av_burstcount), 64'(v.exp_burst));
            repeat (v.wait_cyc) @(negedge clk);
            chk("rd_held", 64'(if_a.av_read), 64'd1);
            chk("rd_addr_stable", 64'(if_a.av_address), 64'(v.exp_addr));
            if_a.av_waitrequest = 1'b0;
            @(negedge clk);
            if_a.av_waitrequest = 1'b1;
            chk("rd_req_dropped", 64'(if_a.av_read), 64'd0);
            for (int i = 0; i < nbeats; i++) begin
                if_a.av_readdatavalid = 1'b1;
                if_a.av_readdata      = beat_data(v.wdata, i);
                q.push_back('{data: beat_data(v.wdata, i), last: (i == nbeats - 1)});
                @(negedge clk);
                if_a.av_readdatavalid = 1'b0;
                repeat (v.gap) @(negedge clk);
            end
        end
        cyc = 0;
        while (done_cnt == start_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("done_count", 64'(done_cnt - start_done), 64'd1);
        chk("err_code", 64'(last_err), 64'(v.exp_err));
        chk("beat_count", 64'(rd_cnt - start_rd), 64'(nbeats));
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        chk("ready_after_done", 64'(if_a.cmd_ready), 64'd1);
        if (v.op == OP_WR && v.exp_err == 2'b00)
            chk("wr_hold_cycles", 64'(wr_cycles - start_wr), 64'(v.wait_cyc + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1);
    end

    initial begin
        int start;
        int cyc;
        // op, addr, len, wdata, wait, gap, exp_err, exp_addr, exp_burst
        vecs[0]  = '{2'b00, 24'h000010, 4'd1, 32'hDEAD_BEEF, 2,   0, 2'b00, 17'h00004, 4'd1};
        vecs[1]  = '{2'b10, 24'h000100, 4'd8, 32'hA000_0000, 0,   1, 2'b00, 17'h00040, 4'd8};
        vecs[2]  = '{2'b01, 24'h000020, 4'd1, 32'h1234_5678, 500, 0, 2'b00, 17'h00008, 4'd1};
        vecs[3]  = '{2'b10, 24'h000100, 4'd0, 32'h0,         0,   0, 2'b10, 17'h0,     4'd0};
        vecs[4]  = '{2'b10, 24'h000100, 4'd9, 32'h0,         0,   0, 2'b10, 17'h0,     4'd0};
        vecs[5]  = '{2'b00, 24'h080000, 4'd1, 32'h0,         0,   0, 2'b01, 17'h0,     4'd0};
        vecs[6]  = '{2'b11, 24'h000000, 4'd1, 32'h0,         0,   0, 2'b10, 17'h0,     4'd0};
        vecs[7]  = '{2'b10, 24'h07FFFC, 4'd1, 32'hC0FF_EE00, 1,   0, 2'b00, 17'h1FFFF, 4'd1};
        vecs[8]  = '{2'b01, 24'h07FFFF, 4'd1, 32'h55AA_55AA, 0,   0, 2'b00, 17'h1FFFF, 4'd1};
        vecs[9]  = '{2'b10, 24'h000040, 4'd8, 32'h1111_0000, 3,   0, 2'b00, 17'h00010, 4'd8};
        vecs[10] = '{2'b10, 24'h000123, 4'd3, 32'hCAFE_0000, 0,   2, 2'b00, 17'h00048, 4'd3};
        vecs[11] = '{2'b00, 24'h000004, 4'd5, 32'h0BAD_F00D, 0,   0, 2'b00, 17'h00001, 4'd1};

        if_a.cmd_valid = 1'b0; if_a.cmd_op = 2'b00; if_a.cmd_addr = '0; if_a.cmd_len = '0;
        if_a.cmd_wdata = '0; if_a.av_waitrequest = 1'b1; if_a.av_readdatavalid = 1'b0;
        if_a.av_readdata = '0;
        if_b.cmd_valid = 1'b0; if_b.cmd_op = 2'b00; if_b.cmd_addr = '0; if_b.cmd_len = '0;
        if_b.cmd_wdata = '0; if_b.av_waitrequest = 1'b1; if_b.av_readdatavalid = 1'b0;
        if_b.av_readdata = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(if_a.cmd_ready), 64'd1);
        chk("rst_strobes", 64'({if_a.av_read, if_a.av_write}), 64'd0);
        chk("rst_outputs", 64'({if_a.rd_valid, if_a.rd_last, if_a.done}), 64'd0);
        chk("rst_err", 64'(if_a.err), 64'd0);
        chk("rst_addr", 64'(if_a.av_address), 64'd0);
        chk("rst_burst", 64'(if_a.av_burstcount), 64'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Stray beats while idle must not reach rd_valid
        start = rd_cnt;
        @(negedge clk);
        if_a.av_readdatavalid = 1'b1;
        if_a.av_readdata      = 32'hFFFF_0000;
        repeat (3) @(negedge clk);
        if_a.av_readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_ignored", 64'(rd_cnt - start), 64'd0);

        // Reset while the burst request is pending
        start = done_cnt;
        @(negedge clk);
        if_a.cmd_valid = 1'b1; if_a.cmd_op = 2'b10; if_a.cmd_addr = 24'h000200; if_a.cmd_len = 4'd4;
        @(negedge clk);
        if_a.cmd_valid = 1'b0;
        chk("mid_rst_read_up", 64'(if_a.av_read), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_read_drop", 64'(if_a.av_read), 64'd0);
        chk("mid_rst_no_done", 64'(if_a.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(if_a.cmd_ready), 64'd1);
        chk("mid_rst_done_count", 64'(done_cnt - start), 64'd0);
        run_vec(vecs[0]);

        // Timeout instance: burst of 4 with only 2 beats supplied
        @(negedge clk);
        if_b.av_waitrequest = 1'b0;
        if_b.cmd_valid = 1'b1; if_b.cmd_op = 2'b10; if_b.cmd_addr = 24'h000300; if_b.cmd_len = 4'd4;
        @(negedge clk);
        if_b.cmd_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if_b.av_readdatavalid = 1'b1;
            if_b.av_readdata      = 32'h7700_0000 + 32'(i);
            @(negedge clk);
            if_b.av_readdatavalid = 1'b0;
            @(negedge clk);
        end
        cyc = 0;
        while (b_done == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("to_done", 64'(b_done), 64'd1);
        chk("to_err", 64'(b_err), 64'(E_TIMEOUT));
        chk("to_beats", 64'(b_rd), 64'd2);
        chk("to_no_last", 64'(b_last), 64'd0);
        chk("to_last_data", 64'(b_data), 64'h7700_0001);
        chk("to_read_low", 64'(if_b.av_read), 64'd0);
        for (int i = 0; i < 2; i++) begin
            if_b.av_readdatavalid = 1'b1;
            @(negedge clk);
            if_b.av_readdatavalid = 1'b0;
            @(negedge clk);
        end
        chk("to_late_ignored", 64'(b_rd), 64'd2);
        chk("to_no_extra_done", 64'(b_done), 64'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
